uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Round-robin arbiter sharing one uart_tx serializer among NUM_REQ byte producers.
//  Accepts one byte per valid/ready handshake and issues a 1-cycle tx_start with stable tx_data.
//  Holds off further grants until tx_done; a watchdog aborts a hung frame and flags err_timeout.
//  Sits between client logic (debug print, status reporter, etc.) and the uart_tx instance.
// PARAMETERS
//  NUM_REQ         4      number of requesters, >=2; IDX_W = $clog2(NUM_REQ)
//  DATA_WIDTH      8      byte width, matches uart_tx tx_data
//  TIMEOUT_CYCLES  65535  max clk cycles in WAIT_DONE before abort, >=2
// PORTS
//  clk          in   1                   system clock, all logic on posedge
//  rst          in   1                   synchronous, active-high reset
//  req_valid    in   NUM_REQ             per-requester byte valid
//  req_data     in   NUM_REQ*DATA_WIDTH  byte i at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ready    out  NUM_REQ             one-hot accept; transfer when valid&ready at posedge
//  tx_start     out  1                   to uart_tx: one-cycle start pulse
//  tx_data      out  DATA_WIDTH          to uart_tx: byte being sent, stable START..WAIT_DONE
//  tx_active    in   1                   from uart_tx: serializer busy
//  tx_done      in   1                   from uart_tx: one-cycle frame-complete pulse
//  busy         out  1                   state != IDLE
//  grant_id     out  IDX_W               index of most recently accepted requester
//  err_timeout  out  1                   one-cycle pulse on watchdog abort
// BEHAVIOUR
//  Reset (rst high at posedge): state=IDLE, tx_start=0, tx_data=0, grant_id=0, err_timeout=0,
//   last_grant=NUM_REQ-1 (req 0 has first priority), wdog=0. req_ready forced 0 while rst=1.
//  FSM: IDLE -> START -> WAIT_DONE -> IDLE.
//  IDLE: req_ready combinational = one-hot of first set req_valid searching from
//   (last_grant+1) mod NUM_REQ upward with wrap; all-zero if none valid or tx_active=1.
//   On accept edge: latch tx_data<=req_data[g], grant_id<=g, last_grant<=g, go START.
//  START: tx_start=1 for exactly this one cycle; req_ready=0; go WAIT_DONE.
//  WAIT_DONE: req_ready=0; wdog cleared on entry, +1 each cycle.
//   tx_done=1 -> IDLE. Else wdog==TIMEOUT_CYCLES-1 -> IDLE, err_timeout=1 in next cycle.
//   tx_done and timeout in same cycle: tx_done wins, no err_timeout.
//  Latency: accept edge -> tx_start high next cycle; tx_done cycle -> IDLE next cycle;
//   earliest next accept is the first IDLE cycle (back-to-back bytes, one idle cycle min).
//  tx_start, tx_data, busy, grant_id, err_timeout are registered; req_ready only combinational.
//  tx_data holds last byte after frame until next accept. tx_done outside WAIT_DONE ignored.
//  Requester dropping req_valid before grant: not served, no state change.
//  Reset mid-frame: all outputs return to reset values at that edge; no pending tx_start.
// TESTING (uart_tx behavioural model or uart_tx with small CLK_FREQ/BAUD ratio)
//  1 Only req0 valid, data 0x41 -> req_ready[0] 1 cycle, tx_start 1 cycle next, tx_data=0x41,
//    busy until cycle after tx_done, grant_id=0, req_ready never asserted during busy.
//  2 All 4 valid at once, data 0x10..0x13 held -> bytes sent 0x10,0x11,0x12,0x13 in order;
//    then after serving 1, req0+req2 valid -> req2 served before req0.
//  3 TIMEOUT_CYCLES=100, model never pulses tx_done -> err_timeout 1 cycle, 100 cycles after
//    first WAIT_DONE cycle's edge; arbiter back in IDLE, next request accepted.
//  4 tx_done and wdog==TIMEOUT_CYCLES-1 coincide -> IDLE, err_timeout stays 0.
//  5 tx_active=1 in IDLE with req1 valid -> req_ready=0 until tx_active falls, then grant.
//  6 rst pulsed 1 cycle during WAIT_DONE -> busy=0, tx_data=0, grant_id=0 next cycle;
//    late tx_done ignored; next request req0 granted first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx serializer among NUM_REQ byte producers.
// One byte is accepted per grant; new grants wait for tx_done or a watchdog abort.
module uart_tx_arbiter #(
  parameter  int NUM_REQ        = 4,
  parameter  int DATA_WIDTH     = 8,
  parameter  int TIMEOUT_CYCLES = 65535,
  localparam int IDX_W          = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_active,
  input  logic                          tx_done,
  output logic                          busy,
  output logic [IDX_W-1:0]              grant_id,
  output logic                          err_timeout
);

  localparam int                 WDOG_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [WDOG_W-1:0]  WDOG_LAST  = WDOG_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W:0]     NUM_REQ_W  = (IDX_W + 1)'(NUM_REQ);
  localparam logic [IDX_W-1:0]   LAST_INIT  = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_DONE
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [IDX_W-1:0]      last_grant;
  logic [IDX_W-1:0]      pick;
  logic                  found;
  logic [DATA_WIDTH-1:0] pick_data;
  logic                  accept;
  logic                  timeout_abort;
  logic [WDOG_W-1:0]     wdog;

  // Search starts one past the previous winner, so req 0 wins first after reset.
  always_comb begin : rr_search
    logic [IDX_W:0] cand;
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant} + (IDX_W + 1)'(k);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (!found && req_valid[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin : data_mux
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == IDX_W'(i)) begin
        pick_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin : fsm_next
    state_nxt     = state;
    req_ready     = '0;
    accept        = 1'b0;
    timeout_abort = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rst && !tx_active && found) begin
          req_ready = NUM_REQ'(1) << pick;
          accept    = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A frame completing on the last watchdog cycle is a success, not an abort.
        if (tx_done) begin
          state_nxt = IDLE;
        end else if (wdog == WDOG_LAST) begin
          state_nxt     = IDLE;
          timeout_abort = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin : fsm_state
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin : out_regs
    if (rst) begin
      tx_start    <= 1'b0;
      tx_data     <= '0;
      busy        <= 1'b0;
      grant_id    <= '0;
      err_timeout <= 1'b0;
      last_grant  <= LAST_INIT;
      wdog        <= '0;
    end else begin
      tx_start    <= accept;
      busy        <= (state_nxt != IDLE);
      err_timeout <= timeout_abort;
      if (accept) begin
        tx_data    <= pick_data;
        grant_id   <= pick;
        last_grant <= pick;
      end
      if (state == START) begin
        wdog <= '0;
      end else if (state == WAIT_DONE) begin
        wdog <= wdog + WDOG_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a small behavioural uart_tx model.
// Stimulus pushes expected {grant_id, byte} pairs; the monitor checks them on each tx_start.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int TMO     = 100;
  localparam int IDX_W   = 2;
  localparam int FRAME   = 5;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ*DW-1:0] req_data = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  tx_start;
  logic [DW-1:0]         tx_data;
  logic                  tx_active;
  logic                  tx_done;
  logic                  busy;
  logic [IDX_W-1:0]      grant_id;
  logic                  err_timeout;

  logic force_active = 1'b0;
  logic force_done   = 1'b0;
  logic model_hang   = 1'b0;
  logic model_active = 1'b0;
  logic model_done   = 1'b0;
  int   model_cnt    = 0;

  int n_chk = 0;
  int n_err = 0;
  logic [IDX_W+DW-1:0] exp_q[$];
  int mon_rd = 0;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_active(tx_active),
    .tx_done(tx_done),
    .busy(busy),
    .grant_id(grant_id),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  assign tx_active = model_active | force_active;
  assign tx_done   = model_done | force_done;

  // uart_tx stand-in: busy for FRAME cycles after tx_start, then a done pulse; ignores rst.
  always @(posedge clk) begin
    model_done <= 1'b0;
    if (tx_start && !model_hang) begin
      model_active <= 1'b1;
      model_cnt    <= FRAME;
    end else if (model_active) begin
      if (model_cnt == 1) begin
        model_active <= 1'b0;
        model_done   <= 1'b1;
      end
      model_cnt <= model_cnt - 1;
    end
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endfunction

  initial begin : monitor
    logic prev_start;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("ready_in_reset", req_ready, 0);
      end else begin
        if (busy) chk("ready_while_busy", req_ready, 0);
        if (tx_start) begin
          chk("start_width", prev_start, 0);
          if (exp_q.size() > mon_rd) begin
            chk($sformatf("byte%0d", mon_rd), {grant_id, tx_data}, exp_q[mon_rd]);
            mon_rd++;
          end else begin
            chk("pending_expect", exp_q.size(), mon_rd + 1);
          end
        end
      end
      prev_start = tx_start;
    end
  end

  initial begin : global_guard
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "simulation did not finish");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid    = '0;
    force_active = 1'b0;
    force_done   = 1'b0;
    model_hang   = 1'b0;
    for (int i = 0; i < 50 && model_active; i++) tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Plays every requester: drops a valid bit after the edge at which it was accepted.
  task automatic serve(input int max_cycles);
    logic [NUM_REQ-1:0] acc;
    int n;
    n = 0;
    while ((req_valid != 0 || busy) && n < max_cycles) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~acc;
      n++;
    end
    chk("serve_bound", n < max_cycles, 1);
  endtask

  task automatic wait_start(input string name);
    int n;
    n = 0;
    while (!tx_start && n < 10) begin
      tick();
      n++;
    end
    chk(name, tx_start, 1);
  endtask

  initial begin : stimulus
    int n;

    // Reset state, with every requester asking
    rst       = 1'b1;
    req_valid = '1;
    req_data  = 32'hDEADBEEF;
    tick();
    chk("rst_ready", req_ready, 0);
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_err", err_timeout, 0);
    req_valid = '0;
    rst       = 1'b0;
    tick();

    // Single byte from req0
    exp_q.push_back({2'd0, 8'h41});
    req_data  = 32'h0000_0041;
    req_valid = 4'b0001;
    #1;
    chk("t1_ready", req_ready, 4'b0001);
    tick();
    chk("t1_start", tx_start, 1);
    chk("t1_data", tx_data, 8'h41);
    chk("t1_busy", busy, 1);
    chk("t1_gid", grant_id, 0);
    chk("t1_ready_drop", req_ready, 0);
    tick();
    chk("t1_start_drop", tx_start, 0);
    n = 0;
    while (!tx_done && n < 50) begin
      tick();
      n++;
    end
    chk("t1_done_seen", tx_done, 1);
    chk("t1_busy_at_done", busy, 1);
    req_valid = '0;
    tick();
    chk("t1_idle", busy, 0);
    chk("t1_data_hold", tx_data, 8'h41);

    // All four at once, then rotation check with req1 served first
    do_reset();
    exp_q.push_back({2'd0, 8'h10});
    exp_q.push_back({2'd1, 8'h11});
    exp_q.push_back({2'd2, 8'h12});
    exp_q.push_back({2'd3, 8'h13});
    req_data  = 32'h1312_1110;
    req_valid = 4'b1111;
    serve(300);
    do_reset();
    req_data = 32'h3332_2130;
    exp_q.push_back({2'd1, 8'h21});
    req_valid = 4'b0010;
    serve(100);
    chk("t2_gid_hold", grant_id, 1);
    exp_q.push_back({2'd2, 8'h32});
    exp_q.push_back({2'd0, 8'h30});
    req_valid = 4'b0101;
    serve(200);

    // Watchdog abort when tx_done never arrives
    do_reset();
    model_hang = 1'b1;
    exp_q.push_back({2'd3, 8'h5A});
    req_data  = 32'h5A00_0000;
    req_valid = 4'b1000;
    wait_start("t3_start_seen");
    req_valid = '0;
    n = 0;
    while (!err_timeout && n < 150) begin
      tick();
      n++;
    end
    chk("t3_timeout_latency", n, 101);
    chk("t3_idle_at_err", busy, 0);
    tick();
    chk("t3_err_pulse", err_timeout, 0);
    model_hang = 1'b0;
    exp_q.push_back({2'd0, 8'h66});
    req_data  = 32'h0000_0066;
    req_valid = 4'b0001;
    serve(100);

    // tx_done on the final watchdog cycle wins over the abort
    do_reset();
    model_hang = 1'b1;
    exp_q.push_back({2'd0, 8'hC4});
    req_data  = 32'h0000_00C4;
    req_valid = 4'b0001;
    wait_start("t4_start_seen");
    req_valid = '0;
    for (int t = 0; t < 100; t++) tick();
    chk("t4_busy_pre", busy, 1);
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    chk("t4_idle", busy, 0);
    chk("t4_no_err", err_timeout, 0);
    tick();
    chk("t4_no_err_late", err_timeout, 0);
    model_hang = 1'b0;

    // tx_active blocks grants in IDLE
    do_reset();
    force_active = 1'b1;
    exp_q.push_back({2'd1, 8'h77});
    req_data  = 32'h0000_7700;
    req_valid = 4'b0010;
    for (int t = 0; t < 4; t++) begin
      #1;
      chk("t5_hold", req_ready, 0);
      tick();
    end
    chk("t5_not_busy", busy, 0);
    force_active = 1'b0;
    #1;
    chk("t5_ready", req_ready, 4'b0010);
    serve(100);

    // Reset mid-frame, late tx_done ignored, priority back to req0
    do_reset();
    exp_q.push_back({2'd2, 8'h99});
    req_data  = 32'h0099_0000;
    req_valid = 4'b0100;
    wait_start("t6_start_seen");
    req_valid = '0;
    tick();
    tick();
    chk("t6_busy_pre", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_data", tx_data, 0);
    chk("t6_gid", grant_id, 0);
    chk("t6_start", tx_start, 0);
    chk("t6_err", err_timeout, 0);
    n = 0;
    while (!model_done && n < 20) begin
      tick();
      n++;
    end
    chk("t6_late_done", model_done, 1);
    tick();
    chk("t6_still_idle", busy, 0);
    exp_q.push_back({2'd0, 8'hA0});
    exp_q.push_back({2'd3, 8'hA3});
    req_data  = 32'hA300_00A0;
    req_valid = 4'b1001;
    serve(100);

    tick();
    chk("all_bytes_sent", mon_rd, exp_q.size());
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
